// File: rtl/nco_freq_sweep_ctrl.sv
// Purpose: steps the 3-bit NCO frequency select through a latched index range, holding each index for a dwell.
// Latency: 1 cycle from start to the first freq_sel/freq_load; all outputs registered.
// Backpressure: none; counting is gated only by sample_tick, and stop aborts at the next edge.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   sample_tick           sample-rate enable; the dwell counter advances only when high
//   start, stop           begin sweep (honoured in IDLE only) / abort to IDLE (highest priority)
//   mode_loop             1 = wrap back to first_idx after last_idx, 0 = single pass
//   first_idx, last_idx   inclusive index range, ascending modulo 8
//   dwell                 sample ticks per step (0 behaves as 1)
//   freq_sel              select to the NCO tuning-word mux
//   freq_load             one-cycle strobe in the cycle freq_sel takes a new value
//   busy                  high while a sweep is running
//   done                  one-cycle strobe at the normal end of a single-pass sweep
module nco_freq_sweep_ctrl #(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_tick,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_loop,
    input  logic [2:0]         first_idx,
    input  logic [2:0]         last_idx,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         freq_sel,
    output logic               freq_load,
    output logic               busy,
    output logic               done
);

    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_lat;
    logic [2:0]         first_lat;
    logic [2:0]         last_lat;
    logic               loop_lat;

    logic [DWELL_W-1:0] cnt_inc;
    logic               step_due;

    // dwell_lat is never 0, so equality on the incremented count always hits
    // before the counter can wrap.
    assign cnt_inc  = cnt + CNT_ONE;
    assign step_due = sample_tick && (cnt_inc == dwell_lat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            dwell_lat <= '0;
            first_lat <= '0;
            last_lat  <= '0;
            loop_lat  <= 1'b0;
            freq_sel  <= '0;
            freq_load <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Strobes default low; only the branches below raise them.
            freq_load <= 1'b0;
            done      <= 1'b0;

            if (stop) begin
                // Abort: freq_sel holds its last value, no strobes.
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            first_lat <= first_idx;
                            last_lat  <= last_idx;
                            loop_lat  <= mode_loop;
                            dwell_lat <= (dwell == '0) ? CNT_ONE : dwell;
                            freq_sel  <= first_idx;
                            freq_load <= 1'b1;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            state     <= DWELL;
                        end
                    end

                    DWELL: begin
                        if (step_due) begin
                            cnt <= '0;
                            if (freq_sel != last_lat) begin
                                // 3-bit add wraps 7 -> 0 for ranges with first > last.
                                freq_sel  <= freq_sel + 3'd1;
                                freq_load <= 1'b1;
                            end else if (loop_lat) begin
                                freq_sel  <= first_lat;
                                freq_load <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (sample_tick) begin
                            cnt <= cnt_inc;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nco_freq_sweep_ctrl.sv
// Purpose: directed, table-driven check of the frequency sweep sequencer.
// Latency: each vector drives inputs at the falling edge and checks outputs 1 time unit after the rising edge.
// Backpressure: not applicable; the bench free-runs the clock and never waits on DUT events.
module tb_nco_freq_sweep_ctrl;

    logic        clk;
    logic        reset;
    logic        sample_tick;
    logic        start;
    logic        stop;
    logic        mode_loop;
    logic [2:0]  first_idx;
    logic [2:0]  last_idx;
    logic [23:0] dwell;
    logic [2:0]  freq_sel;
    logic        freq_load;
    logic        busy;
    logic        done;

    int n_vec  = 0;
    int n_miss = 0;

    nco_freq_sweep_ctrl #(.DWELL_W(24)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .start       (start),
        .stop        (stop),
        .mode_loop   (mode_loop),
        .first_idx   (first_idx),
        .last_idx    (last_idx),
        .dwell       (dwell),
        .freq_sel    (freq_sel),
        .freq_load   (freq_load),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          st;
        bit          sp;
        bit          lp;
        bit [2:0]    fi;
        bit [2:0]    li;
        bit [23:0]   dw;
        bit          tk;
        bit [2:0]    e_sel;
        bit          e_load;
        bit          e_busy;
        bit          e_done;
    } vec_t;

    vec_t vq[$];

    function automatic void add(string nm, bit st, bit sp, bit lp, bit [2:0] fi, bit [2:0] li,
                                bit [23:0] dw, bit tk, bit [2:0] es, bit el, bit eb, bit ed);
        vec_t v;
        v.name = nm; v.st = st; v.sp = sp; v.lp = lp; v.fi = fi; v.li = li; v.dw = dw; v.tk = tk;
        v.e_sel = es; v.e_load = el; v.e_busy = eb; v.e_done = ed;
        vq.push_back(v);
    endfunction

    task automatic check(string nm, bit [2:0] es, bit el, bit eb, bit ed);
        n_vec++;
        if (freq_sel !== es || freq_load !== el || busy !== eb || done !== ed) begin
            n_miss++;
            $display("FAIL %s: got sel=%0d load=%b busy=%b done=%b, want sel=%0d load=%b busy=%b done=%b",
                     nm, freq_sel, freq_load, busy, done, es, el, eb, ed);
        end
    endtask

    task automatic drive(bit st, bit sp, bit lp, bit [2:0] fi, bit [2:0] li, bit [23:0] dw, bit tk);
        start = st; stop = sp; mode_loop = lp; first_idx = fi; last_idx = li; dwell = dw; sample_tick = tk;
    endtask

    initial begin
        // ---------------- vector table ----------------
        // Single pass 0..2, dwell 3, tick every cycle.
        add("sp_start", 1, 0, 0, 0, 2, 3, 1, 0, 1, 1, 0);
        add("sp_e1",    0, 0, 0, 0, 2, 3, 1, 0, 0, 1, 0);
        add("sp_e2",    0, 0, 0, 0, 2, 3, 1, 0, 0, 1, 0);
        add("sp_e3",    0, 0, 0, 0, 2, 3, 1, 1, 1, 1, 0);
        add("sp_e4",    0, 0, 0, 0, 2, 3, 1, 1, 0, 1, 0);
        add("sp_e5",    0, 0, 0, 0, 2, 3, 1, 1, 0, 1, 0);
        add("sp_e6",    0, 0, 0, 0, 2, 3, 1, 2, 1, 1, 0);
        add("sp_e7",    0, 0, 0, 0, 2, 3, 1, 2, 0, 1, 0);
        add("sp_e8",    0, 0, 0, 0, 2, 3, 1, 2, 0, 1, 0);
        add("sp_done",  0, 0, 0, 0, 2, 3, 1, 2, 0, 0, 1);
        add("sp_idle",  0, 0, 0, 0, 2, 3, 1, 2, 0, 0, 0);
        // Wrap 6..1 with dwell 0; start re-pulsed mid-sweep with other config.
        add("wr_start", 1, 0, 0, 6, 1, 0, 1, 6, 1, 1, 0);
        add("wr_7",     0, 0, 0, 6, 1, 0, 1, 7, 1, 1, 0);
        add("wr_0_st",  1, 0, 1, 3, 3, 5, 1, 0, 1, 1, 0);
        add("wr_1",     0, 0, 0, 2, 5, 9, 1, 1, 1, 1, 0);
        add("wr_done",  0, 0, 0, 6, 1, 0, 1, 1, 0, 0, 1);
        add("wr_idle",  0, 0, 0, 6, 1, 0, 1, 1, 0, 0, 0);
        // Tick gating: 1..2, dwell 2, tick every 4th cycle.
        add("tg_start", 1, 0, 0, 1, 2, 2, 0, 1, 1, 1, 0);
        for (int i = 1; i <= 16; i++)
            add($sformatf("tg_c%0d", i), 0, 0, 0, 1, 2, 2, (i % 4) == 0,
                (i < 8) ? 3'd1 : 3'd2, i == 8, i < 16, i == 16);
        add("tg_idle",  0, 0, 0, 1, 2, 2, 0, 2, 0, 0, 0);
        // Loop 3..4, dwell 2, then stop+start on a terminal tick.
        add("lp_start", 1, 0, 1, 3, 4, 2, 1, 3, 1, 1, 0);
        add("lp_e1",    0, 0, 1, 3, 4, 2, 1, 3, 0, 1, 0);
        add("lp_e2",    0, 0, 1, 3, 4, 2, 1, 4, 1, 1, 0);
        add("lp_e3",    0, 0, 1, 3, 4, 2, 1, 4, 0, 1, 0);
        add("lp_e4",    0, 0, 1, 3, 4, 2, 1, 3, 1, 1, 0);
        add("lp_e5",    0, 0, 1, 3, 4, 2, 1, 3, 0, 1, 0);
        add("lp_e6",    0, 0, 1, 3, 4, 2, 1, 4, 1, 1, 0);
        add("lp_e7",    0, 0, 1, 3, 4, 2, 1, 4, 0, 1, 0);
        add("lp_stop",  1, 1, 1, 3, 4, 2, 1, 4, 0, 0, 0);
        // Restart in the first IDLE cycle: one-step single pass 5..5, dwell 1.
        add("rs_start", 1, 0, 0, 5, 5, 1, 1, 5, 1, 1, 0);
        add("rs_done",  0, 0, 0, 5, 5, 1, 1, 5, 0, 0, 1);
        add("rs_idle",  0, 0, 0, 5, 5, 1, 1, 5, 0, 0, 0);
        // Constant frequency in loop mode: periodic load at the same index.
        add("cf_start", 1, 0, 1, 2, 2, 2, 1, 2, 1, 1, 0);
        add("cf_e1",    0, 0, 1, 2, 2, 2, 1, 2, 0, 1, 0);
        add("cf_e2",    0, 0, 1, 2, 2, 2, 1, 2, 1, 1, 0);
        add("cf_notk",  0, 0, 1, 2, 2, 2, 0, 2, 0, 1, 0);
        add("cf_e3",    0, 0, 1, 2, 2, 2, 1, 2, 0, 1, 0);
        add("cf_e4",    0, 0, 1, 2, 2, 2, 1, 2, 1, 1, 0);
        add("cf_stop",  0, 1, 1, 2, 2, 2, 1, 2, 0, 0, 0);
        add("cf_idle",  0, 0, 1, 2, 2, 2, 1, 2, 0, 0, 0);

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("reset_hold", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table ----------------
        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].st, vq[i].sp, vq[i].lp, vq[i].fi, vq[i].li, vq[i].dw, vq[i].tk);
            @(posedge clk); #1;
            check(vq[i].name, vq[i].e_sel, vq[i].e_load, vq[i].e_busy, vq[i].e_done);
        end

        // ---------------- asynchronous reset mid-sweep ----------------
        @(negedge clk);
        drive(1, 0, 0, 4, 7, 1, 1);
        @(posedge clk); #1;
        check("ar_start", 4, 1, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 4, 7, 1, 1);
        @(posedge clk); #1;
        check("ar_sel5", 5, 1, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        check("ar_async", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("ar_idle%0d", i), 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(1, 0, 0, 7, 7, 1, 1);
        @(posedge clk); #1;
        check("ar_restart", 7, 1, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 7, 7, 1, 1);
        @(posedge clk); #1;
        check("ar_done", 7, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
